// File: rtl/mem_arb_pkg.sv
// Shared widths, requester id type and access-kind decode for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned CNT_W   = 16;

  typedef logic [0:0] req_id_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } acc_kind_t;

  // A read strobe takes precedence over a simultaneous write strobe
  function automatic acc_kind_t acc_kind(input logic rd, input logic wr);
    if (rd) return READ;
    if (wr) return WRITE;
    return NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of mem_arbiter; slave = arbiter side, master = environment side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
);
  import mem_arb_pkg::*;

  logic [ADDR_W-1:0] req0_addr;
  logic              req0_rd;
  logic              req0_wr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_stall;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;
  logic [CNT_W-1:0]  req0_grants;

  logic [ADDR_W-1:0] req1_addr;
  logic              req1_rd;
  logic              req1_wr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_stall;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;
  logic [CNT_W-1:0]  req1_grants;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_addr, req0_rd, req0_wr, req0_wdata,
    input  req1_addr, req1_rd, req1_wr, req1_wdata,
    input  mem_rdata,
    output req0_stall, req0_rvalid, req0_rdata, req0_grants,
    output req1_stall, req1_rvalid, req1_rdata, req1_grants,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0_addr, req0_rd, req0_wr, req0_wdata,
    output req1_addr, req1_rd, req1_wr, req1_wdata,
    output mem_rdata,
    input  req0_stall, req0_rvalid, req0_rdata, req0_grants,
    input  req1_stall, req1_rvalid, req1_rdata, req1_grants,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: rr breaks ties, rr_nxt points at the loser after any grant.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] act,
  input  req_id_t            rr,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            rr_nxt
);

  always_comb begin
    gnt    = '0;
    rr_nxt = rr;
    case (act)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr == 1'b1) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
    // Idle cycles leave the pointer where it was
    if (|gnt) rr_nxt = req_id_t'(~gnt[1]);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with pipelined read responses.
// Define MEM_ARBITER_STATS_EN to build the per-requester 16-bit grant counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  acc_kind_t          kind0;
  acc_kind_t          kind1;
  acc_kind_t          gnt_kind;
  logic [NUM_REQ-1:0] req_act;
  logic [NUM_REQ-1:0] arb_act;
  logic [NUM_REQ-1:0] gnt;
  req_id_t            rr_q;
  req_id_t            rr_nxt;
  req_id_t            gnt_id;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_wdata;
  logic               rsp_pend_q;
  req_id_t            rsp_id_q;
  logic               rvalid0;
  logic               rvalid1;

  // Request decode; nothing is offered to the arbiter while in reset
  always_comb begin
    kind0   = acc_kind(bus.req0_rd, bus.req0_wr);
    kind1   = acc_kind(bus.req1_rd, bus.req1_wr);
    req_act = {kind1 != NONE, kind0 != NONE};
    arb_act = RST ? '0 : req_act;
  end

  rr_arb2 u_rr_arb2 (
    .act    (arb_act),
    .rr     (rr_q),
    .gnt    (gnt),
    .rr_nxt (rr_nxt)
  );

  // Steer the granted access onto the memory port
  always_comb begin
    gnt_id    = req_id_t'(gnt[1]);
    gnt_kind  = NONE;
    gnt_addr  = '0;
    gnt_wdata = '0;
    if (gnt[0]) begin
      gnt_kind  = kind0;
      gnt_addr  = bus.req0_addr;
      gnt_wdata = bus.req0_wdata;
    end else if (gnt[1]) begin
      gnt_kind  = kind1;
      gnt_addr  = bus.req1_addr;
      gnt_wdata = bus.req1_wdata;
    end
    bus.mem_en     = |gnt;
    bus.mem_we     = (gnt_kind == WRITE);
    bus.mem_addr   = gnt_addr;
    bus.mem_wdata  = (gnt_kind == WRITE) ? gnt_wdata : '0;
    bus.req0_stall = req_act[0] & ~gnt[0];
    bus.req1_stall = req_act[1] & ~gnt[1];
  end

  // Round-robin pointer and one-deep read response tracker
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q       <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      rr_q       <= rr_nxt;
      rsp_pend_q <= (gnt_kind == READ);
      if (gnt_kind == READ) rsp_id_q <= gnt_id;
    end
  end

  // Memory data is routed only to the requester that owns the response
  always_comb begin
    rvalid0         = rsp_pend_q & ~RST & (rsp_id_q == 1'b0);
    rvalid1         = rsp_pend_q & ~RST & (rsp_id_q == 1'b1);
    bus.req0_rvalid = rvalid0;
    bus.req1_rvalid = rvalid1;
    bus.req0_rdata  = rvalid0 ? bus.mem_rdata : '0;
    bus.req1_rdata  = rvalid1 ? bus.mem_rdata : '0;
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [CNT_W-1:0] grants_q [NUM_REQ];

  // Free-running grant counters, wrapping at 16 bits
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (RST) begin
        grants_q[i] <= '0;
      end else if (gnt[i]) begin
        grants_q[i] <= grants_q[i] + CNT_W'(1);
      end
    end
  end

  assign bus.req0_grants = grants_q[0];
  assign bus.req1_grants = grants_q[1];
`else
  assign bus.req0_grants = '0;
  assign bus.req1_grants = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Power-up memory contents; untouched words read back as this pattern
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5A5A5, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic drv(input int n, input logic rd, input logic wr, input logic [7:0] a,
                     input logic [31:0] d);
    if (n == 0) begin
      bus.req0_rd = rd; bus.req0_wr = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_rd = rd; bus.req1_wr = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drv(1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Synchronous RAM: samples the port at negedge (stable), commits at posedge
  logic [31:0] bmem    [256];
  logic        bmem_ok [256];
  initial begin
    logic        en, we;
    logic [7:0]  a;
    logic [31:0] wd;
    for (int i = 0; i < 256; i++) bmem_ok[i] = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge CLK);
      en = bus.mem_en; we = bus.mem_we; a = bus.mem_addr; wd = bus.mem_wdata;
      @(posedge CLK);
      if (en && we) begin
        bmem[a]    = wd;
        bmem_ok[a] = 1'b1;
      end
      if (en && !we) bus.mem_rdata = bmem_ok[a] ? bmem[a] : init_word(a);
      else           bus.mem_rdata = $urandom;
    end
  end

  // Reference model: per cycle, decide the winner from the arbitration rules and check every output
  logic        m_rr    = 1'b0;
  logic        m_pend  = 1'b0;
  logic        m_pid   = 1'b0;
  logic [31:0] m_pdata = 32'h0;
  logic [15:0] m_cnt  [2];
  logic [31:0] m_mem  [256];
  logic        m_ok   [256];
  initial begin
    logic        rd [2];
    logic        wr [2];
    logic        act [2];
    logic [7:0]  ad [2];
    logic [31:0] wd [2];
    logic        g_any, g, e_rd, e_we, rv [2];
    m_cnt[0] = 16'd0;
    m_cnt[1] = 16'd0;
    for (int i = 0; i < 256; i++) m_ok[i] = 1'b0;
    forever begin
      @(negedge CLK);
      rd[0] = bus.req0_rd; wr[0] = bus.req0_wr; ad[0] = bus.req0_addr; wd[0] = bus.req0_wdata;
      rd[1] = bus.req1_rd; wr[1] = bus.req1_wr; ad[1] = bus.req1_addr; wd[1] = bus.req1_wdata;
      for (int n = 0; n < 2; n++) act[n] = rd[n] | wr[n];
      g_any = 1'b0;
      g     = 1'b0;
      if (!RST && (act[0] || act[1])) begin
        g_any = 1'b1;
        g     = (act[0] && act[1]) ? m_rr : act[1];
      end
      e_rd  = g_any && rd[g];
      e_we  = g_any && !rd[g];
      rv[0] = !RST && m_pend && (m_pid == 1'b0);
      rv[1] = !RST && m_pend && (m_pid == 1'b1);

      chk("mem_en",      32'(bus.mem_en),      32'(g_any));
      chk("mem_we",      32'(bus.mem_we),      32'(e_we));
      chk("mem_addr",    32'(bus.mem_addr),    g_any ? 32'(ad[g]) : 32'h0);
      chk("mem_wdata",   bus.mem_wdata,        e_we ? wd[g] : 32'h0);
      chk("req0_stall",  32'(bus.req0_stall),  32'(act[0] && !(g_any && g == 1'b0)));
      chk("req1_stall",  32'(bus.req1_stall),  32'(act[1] && !(g_any && g == 1'b1)));
      chk("req0_rvalid", 32'(bus.req0_rvalid), 32'(rv[0]));
      chk("req1_rvalid", 32'(bus.req1_rvalid), 32'(rv[1]));
      chk("req0_rdata",  bus.req0_rdata,       rv[0] ? m_pdata : 32'h0);
      chk("req1_rdata",  bus.req1_rdata,       rv[1] ? m_pdata : 32'h0);
      chk("req0_grants", 32'(bus.req0_grants), STATS ? 32'(m_cnt[0]) : 32'h0);
      chk("req1_grants", 32'(bus.req1_grants), STATS ? 32'(m_cnt[1]) : 32'h0);

      if (RST) begin
        m_rr = 1'b0; m_pend = 1'b0; m_pid = 1'b0;
        m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
      end else begin
        m_pend = e_rd;
        if (e_rd) begin
          m_pid   = g;
          m_pdata = m_ok[ad[g]] ? m_mem[ad[g]] : init_word(ad[g]);
        end
        if (e_we) begin
          m_mem[ad[g]] = wd[g];
          m_ok[ad[g]]  = 1'b1;
        end
        if (g_any) begin
          m_rr     = ~g;
          m_cnt[g] = m_cnt[g] + 16'd1;
        end
      end
    end
  end

  initial begin
    logic        hold [2];
    int unsigned r;

    RST = 1'b1;
    idle();
    cyc();
    cyc();
    RST = 1'b0;
    neg();
    chk("rst_grants0", 32'(bus.req0_grants), 32'h0);
    chk("rst_mem_en",  32'(bus.mem_en),      32'h0);

    // Lone read, zero added latency, response next cycle
    cyc(); drv(0, 1'b1, 1'b0, 8'h10, 32'h0);
    neg();
    chk("t1_en",     32'(bus.mem_en),     32'h1);
    chk("t1_addr",   32'(bus.mem_addr),   32'h10);
    chk("t1_stall0", 32'(bus.req0_stall), 32'h0);
    cyc(); idle();
    neg();
    chk("t1_rvalid0", 32'(bus.req0_rvalid), 32'h1);
    chk("t1_rdata0",  bus.req0_rdata,       32'hDEADBEEF);
    chk("t1_rvalid1", 32'(bus.req1_rvalid), 32'h0);

    // rr is now 1: req1 write beats req0 read to the same address
    cyc(); drv(1, 1'b0, 1'b1, 8'h05, 32'h12345678); drv(0, 1'b1, 1'b0, 8'h05, 32'h0);
    neg();
    chk("t3_we",     32'(bus.mem_we),     32'h1);
    chk("t3_wdata",  bus.mem_wdata,       32'h12345678);
    chk("t3_stall0", 32'(bus.req0_stall), 32'h1);
    chk("t3_stall1", 32'(bus.req1_stall), 32'h0);
    cyc(); drv(1, 1'b0, 1'b0, 8'h00, 32'h0);
    neg();
    chk("t3_rd_en",  32'(bus.mem_en),     32'h1);
    chk("t3_rd_we",  32'(bus.mem_we),     32'h0);
    chk("t3_stall0b", 32'(bus.req0_stall), 32'h0);
    cyc(); idle();
    neg();
    chk("t3_rvalid0", 32'(bus.req0_rvalid), 32'h1);
    chk("t3_rdata0",  bus.req0_rdata,       32'h12345678);

    // rd and wr together behave as a read
    cyc(); drv(0, 1'b1, 1'b1, 8'h05, 32'hFFFF0000);
    neg();
    chk("t5_we",    32'(bus.mem_we),    32'h0);
    chk("t5_wdata", bus.mem_wdata,      32'h0);
    cyc(); idle();
    neg();
    chk("t5_rvalid0", 32'(bus.req0_rvalid), 32'h1);
    chk("t5_rdata0",  bus.req0_rdata,       32'h12345678);

    // Both read every cycle after reset: grants alternate starting with req0
    cyc(); RST = 1'b1;
    cyc(); RST = 1'b0;
    drv(0, 1'b1, 1'b0, 8'h20, 32'h0);
    drv(1, 1'b1, 1'b0, 8'h21, 32'h0);
    for (int k = 0; k < 6; k++) begin
      neg();
      chk("t2_addr",   32'(bus.mem_addr),   (k % 2 == 1) ? 32'h21 : 32'h20);
      chk("t2_stall0", 32'(bus.req0_stall), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("t2_stall1", 32'(bus.req1_stall), (k % 2 == 1) ? 32'h0 : 32'h1);
      chk("t2_rvalid0", 32'(bus.req0_rvalid), (k > 0 && k % 2 == 1) ? 32'h1 : 32'h0);
      chk("t2_rvalid1", 32'(bus.req1_rvalid), (k > 0 && k % 2 == 0) ? 32'h1 : 32'h0);
      chk("t2_rdata0",  bus.req0_rdata, (k > 0 && k % 2 == 1) ? 32'hA5A5A520 : 32'h0);
      chk("t2_rdata1",  bus.req1_rdata, (k > 0 && k % 2 == 0) ? 32'hA5A5A521 : 32'h0);
      if (k < 5) cyc();
    end
    cyc(); idle();
    neg();
    chk("t2_last_rvalid1", 32'(bus.req1_rvalid), 32'h1);
    chk("t2_last_rdata1",  bus.req1_rdata,       32'hA5A5A521);

    // Reset lands in the response cycle of a read
    cyc(); drv(0, 1'b1, 1'b0, 8'h20, 32'h0);
    neg();
    chk("t4_en", 32'(bus.mem_en), 32'h1);
    cyc(); RST = 1'b1; drv(1, 1'b1, 1'b0, 8'h21, 32'h0);
    neg();
    chk("t4_rvalid0", 32'(bus.req0_rvalid), 32'h0);
    chk("t4_rvalid1", 32'(bus.req1_rvalid), 32'h0);
    chk("t4_en_rst",  32'(bus.mem_en),      32'h0);
    chk("t4_stall0",  32'(bus.req0_stall),  32'h1);
    chk("t4_stall1",  32'(bus.req1_stall),  32'h1);
    cyc(); RST = 1'b0;
    neg();
    chk("t4_rr0_addr", 32'(bus.mem_addr),    32'h20);
    chk("t4_grants0",  32'(bus.req0_grants), 32'h0);
    chk("t4_grants1",  32'(bus.req1_grants), 32'h0);
    cyc(); idle();
    neg();

    // Random traffic; a stalled requester holds its request
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      RST = ($urandom_range(0, 59) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          r = $urandom_range(0, 19);
          drv(n, (r >= 8 && r <= 13) || r == 19, r >= 14, 8'($urandom_range(0, 7)), $urandom);
        end
      end
      neg();
      hold[0] = bus.req0_stall;
      hold[1] = bus.req1_stall;
    end

    // 65537 back-to-back grants to req0
    cyc(); RST = 1'b1; idle();
    cyc(); RST = 1'b0; drv(0, 1'b1, 1'b0, 8'h00, 32'h0);
    repeat (65535) cyc();
    neg();
    chk("t6_ffff", 32'(bus.req0_grants), STATS ? 32'h0000FFFF : 32'h0);
    cyc();
    neg();
    chk("t6_wrap", 32'(bus.req0_grants), 32'h0);
    cyc(); idle();
    neg();
    chk("t6_after_wrap", 32'(bus.req0_grants), STATS ? 32'h1 : 32'h0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory word address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 reqN_addr  input  ADDR_W  requester N word address, N in {0,1}.
REQ-006 reqN_rd  input  1  requester N read request.
REQ-007 reqN_wr  input  1  requester N write request.
REQ-008 reqN_wdata  input  DATA_W  requester N write data.
REQ-009 reqN_stall  output  1  requester N must hold its request stable and not advance.
REQ-010 reqN_rvalid  output  1  read data for requester N is valid this cycle.
REQ-011 reqN_rdata  output  DATA_W  read data for requester N.
REQ-012 mem_en, mem_we  output  1 each  memory access enable, write enable.
REQ-013 mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W;  mem_rdata  input  DATA_W, valid one cycle after a read access.
REQ-014 reqN_grants  output  16  count of granted accesses for requester N.

Function
REQ-015 Requester N is active when reqN_rd or reqN_wr is 1; if both are 1, the request is a read and wr is ignored.
REQ-016 At most one access is granted per cycle; a lone active requester is granted in the same cycle (zero added latency).
REQ-017 When both are active, the requester selected by the 1-bit round-robin pointer rr is granted; after any grant, rr points to the non-granted requester.
REQ-018 With no active requester, rr holds its value.
REQ-019 Granted access drives mem_en=1, mem_addr=reqN_addr, mem_we=1 only for writes, and mem_wdata=reqN_wdata (0 for reads); with no grant, all mem_* outputs are 0.
REQ-020 reqN_stall=1 combinationally iff requester N is active and not granted this cycle.
REQ-021 A granted read sets registered rsp_pend=1 and rsp_id=N; in the next cycle reqN_rvalid=1 and reqN_rdata=mem_rdata for requester rsp_id only.
REQ-022 reqN_rdata is 0 whenever reqN_rvalid is 0.
REQ-023 Reads are pipelined: a new grant is allowed in the same cycle as a read response.
REQ-024 Simultaneous write by one requester and read by the other to the same address: the granted access takes effect first; the loser's access is issued in a later cycle and observes the earlier write.
REQ-025 Writes produce no rvalid; a write is complete in its grant cycle.
REQ-026 reqN_grants increments by 1 on each grant to requester N and wraps from 0xFFFF to 0x0000.

Reset
REQ-027 While RST=1 at posedge CLK: rr=0, rsp_pend=0, rsp_id=0, grant counters=0.
REQ-028 A read granted in the cycle RST is asserted produces no rvalid; its response is dropped.
REQ-029 During RST=1, no grants are issued; mem_en=0, both stall outputs equal their active inputs, and both rvalid outputs are 0.

Configuration
REQ-030 Macro MEM_ARBITER_STATS_EN defined: grant counters are implemented as specified in REQ-026.
REQ-031 Macro MEM_ARBITER_STATS_EN undefined: no counter registers are implemented, and reqN_grants are tied to 0; all other behaviour is identical.

Structure
REQ-032 The shared package mem_arb_pkg holds ADDR_W and DATA_W defaults, NUM_REQ=2, the req_id_t typedef (1 bit), and the access-kind enum (NONE, READ, WRITE).
REQ-033 The arbitration decision lives in sub-module rr_arb2 (two active inputs plus rr in; grant one-hot plus next rr out); mem_arbiter owns the response pipeline and the counters.

Verification
REQ-034 Test 1: req0 read addr 0x10 alone, with memory returning 0xDEADBEEF. Expect mem_en=1 and mem_addr=0x10 in cycle T; req0_rvalid=1 and req0_rdata=0xDEADBEEF in T+1; req0_stall=0 throughout.
REQ-035 Test 2: both requesters read every cycle for 6 cycles after reset. Expect grants alternating 0,1,0,1,0,1; each requester stalls on alternate cycles; each rvalid is routed to the correct requester only.
REQ-036 Test 3: req1 writes 0x12345678 to 0x05 while req0 reads 0x05 in the same cycle, with rr=1. Expect the write in cycle T; the read granted in T+1; req0_rdata=0x12345678 in T+2.
REQ-037 Test 4: assert RST in the cycle after a read grant. Expect req_rvalid=0 in the response cycle; rr=0 and counters=0 after reset.
REQ-038 Test 5: req0 asserts rd=1 and wr=1 together. Expect mem_we=0 and a read response in the next cycle.
REQ-039 Test 6 (MEM_ARBITER_STATS_EN defined): 65537 grants to req0. Expect req0_grants=1 after wrap. With the macro undefined: req0_grants=0 throughout.
